// File: rtl/vga_pkg.sv
// Shared 640x480 timing defaults and the colour-bar palette for the VGA timing generator.
// Constants and a pure lookup only: no state, no latency, no flow control.
package vga_pkg;
    localparam int CNT_W        = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int NUM_BARS     = 8;

    typedef logic [23:0] rgb_t;

    // Bars run left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb_t bar_rgb(input logic [2:0] idx);
        bar_rgb = 24'h000000;
        case (idx)
            3'd0: bar_rgb = 24'hFFFFFF;
            3'd1: bar_rgb = 24'hFFFF00;
            3'd2: bar_rgb = 24'h00FFFF;
            3'd3: bar_rgb = 24'h00FF00;
            3'd4: bar_rgb = 24'hFF00FF;
            3'd5: bar_rgb = 24'hFF0000;
            3'd6: bar_rgb = 24'h0000FF;
            3'd7: bar_rgb = 24'h000000;
            default: bar_rgb = 24'h000000;
        endcase
    endfunction
endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: counts enabled ticks 0..TOTAL-1, exposes the next value and the wrap edge.
// Next value is combinational, count registered on clk; en gates every change (no other backpressure).
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             wrap
);
    localparam logic [CNT_W-1:0] TC = CNT_W'(TOTAL - 1);

    always_comb begin
        wrap    = en && (cnt == TC);
        cnt_nxt = cnt;
        if (wrap) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // Reset parks on the terminal count so the first enable lands on 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= TC;
        end else begin
            cnt <= cnt_nxt;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing (counters, syncs, de, line/frame pulses); colour bars on rgb with VGA_TEST_PATTERN_EN.
// Outputs registered with the counters (zero relative latency); pm gates all state, pulses drop when pm=0.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pm,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line_start,
    output logic             frame_start,
    output logic [23:0]      rgb
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);

    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             h_wrap;
    logic             v_wrap;
    logic             hsync_nxt;
    logic             vsync_nxt;
    logic             de_nxt;

    vga_axis_cnt #(.TOTAL(H_TOTAL)) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .en      (pm),
        .cnt     (h_cnt),
        .cnt_nxt (h_nxt),
        .wrap    (h_wrap)
    );

    vga_axis_cnt #(.TOTAL(V_TOTAL)) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .en      (h_wrap),
        .cnt     (v_cnt),
        .cnt_nxt (v_nxt),
        .wrap    (v_wrap)
    );

    // Decode from the values the counters are about to load, so outputs line up with them.
    always_comb begin
        hsync_nxt = !((h_nxt >= HS_BEG) && (h_nxt <= HS_END));
        vsync_nxt = !((v_nxt >= VS_BEG) && (v_nxt <= VS_END));
        de_nxt    = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // A wrap only happens on a pm edge, so the pulses self-clear otherwise.
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            if (pm) begin
                hsync <= hsync_nxt;
                vsync <= vsync_nxt;
                de    <= de_nxt;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / NUM_BARS);

    logic [2:0] bar_idx;

    assign bar_idx = 3'(h_nxt / BAR_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb <= '0;
        end else if (pm) begin
            rgb <= de_nxt ? bar_rgb(bar_idx) : '0;
        end
    end
`else
    assign rgb = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default-geometry and reduced-geometry instances share stimulus; a raster-index model predicts every output.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
        logic [23:0] rgb;
    } obs_t;

`ifdef VGA_TEST_PATTERN_EN
    localparam bit PATTERN = 1'b1;
`else
    localparam bit PATTERN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pm  = 1'b0;

    logic [9:0]  h_f, v_f, h_s, v_s;
    logic        hs_f, vs_f, de_f, ls_f, fs_f;
    logic        hs_s, vs_s, de_s, ls_s, fs_s;
    logic [23:0] rgb_f, rgb_s;

    obs_t obs_f, obs_s;
    assign obs_f = {h_f, v_f, hs_f, vs_f, de_f, ls_f, fs_f, rgb_f};
    assign obs_s = {h_s, v_s, hs_s, vs_s, de_s, ls_s, fs_s, rgb_s};

    longint n;       // pm edges accepted since reset
    bit     pulsed;  // last clk edge carried pm
    int     checks;
    int     errors;

    always #5 clk = ~clk;

    vga_timing_gen dut_f (
        .clk(clk), .rst(rst), .pm(pm), .h_cnt(h_f), .v_cnt(v_f), .hsync(hs_f), .vsync(vs_f),
        .de(de_f), .line_start(ls_f), .frame_start(fs_f), .rgb(rgb_f)
    );

    vga_timing_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_s (
        .clk(clk), .rst(rst), .pm(pm), .h_cnt(h_s), .v_cnt(v_s), .hsync(hs_s), .vsync(vs_s),
        .de(de_s), .line_start(ls_s), .frame_start(fs_s), .rgb(rgb_s)
    );

    // Position after n pixels counted from the pre-first-pixel point (last pixel of last line).
    function automatic obs_t model(input int ha, input int hfp, input int hsw, input int hbp,
                                   input int va, input int vfp, input int vsw, input int vbp);
        obs_t        o;
        logic [23:0] bars [8];
        int          ht, vt, h, v;
        longint      tot, l;
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
        ht  = ha + hfp + hsw + hbp;
        vt  = va + vfp + vsw + vbp;
        tot = longint'(ht) * vt;
        l   = (tot - 1 + n) % tot;
        h   = int'(l % ht);
        v   = int'(l / ht);
        o.h   = 10'(h);
        o.v   = 10'(v);
        o.hs  = !(h >= ha + hfp && h < ha + hfp + hsw);
        o.vs  = !(v >= va + vfp && v < va + vfp + vsw);
        o.de  = (h < ha) && (v < va);
        o.ls  = pulsed && (h == 0);
        o.fs  = pulsed && (h == 0) && (v == 0);
        o.rgb = (PATTERN && o.de) ? bars[h / (ha / 8)] : 24'h0;
        return o;
    endfunction

    function automatic obs_t exp_f();
        return model(640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic obs_t exp_s();
        return model(64, 4, 8, 4, 24, 2, 2, 3);
    endfunction

    task automatic step(input bit p);
        pm = p;
        @(posedge clk);
        #1;
        if (p) n++;
        pulsed = p;
    endtask

    task automatic test_reset();
        obs_t ef, es;
        pm = 1'b0;
        rst = 1'b1;
        n = 0;
        pulsed = 1'b0;
        #12;
        ef = exp_f(); es = exp_s();
        checks += 3;
        if (obs_f !== ef) begin errors++; $display("FAIL reset_full got %h exp %h", obs_f, ef); end
        if (obs_s !== es) begin errors++; $display("FAIL reset_small got %h exp %h", obs_s, es); end
        if ({h_f, v_f, hs_f, vs_f, de_f, ls_f, fs_f, rgb_f} !== {10'd799, 10'd524, 5'b11000, 24'h0}) begin
            errors++; $display("FAIL reset_const got h=%0d v=%0d", h_f, v_f);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        checks += 1;
        if (obs_f !== ef) begin errors++; $display("FAIL reset_release got %h exp %h", obs_f, ef); end
    endtask

    task automatic test_first_pm();
        obs_t ef, es;
        step(1'b1);
        ef = exp_f(); es = exp_s();
        checks += 4;
        if (obs_f !== ef) begin errors++; $display("FAIL first_pm_full got %h exp %h", obs_f, ef); end
        if (obs_s !== es) begin errors++; $display("FAIL first_pm_small got %h exp %h", obs_s, es); end
        if ({h_f, v_f, de_f, fs_f, ls_f, hs_f, vs_f} !== {10'd0, 10'd0, 5'b11111}) begin
            errors++; $display("FAIL first_pm_const got h=%0d v=%0d de=%b fs=%b ls=%b", h_f, v_f, de_f, fs_f, ls_f);
        end
        if (rgb_f !== (PATTERN ? 24'hFFFFFF : 24'h0)) begin
            errors++; $display("FAIL rgb_h0 got %h", rgb_f);
        end
        step(1'b0);
        ef = exp_f();
        checks += 2;
        if (obs_f !== ef) begin errors++; $display("FAIL hold_full got %h exp %h", obs_f, ef); end
        if ({ls_f, fs_f, h_f} !== {2'b00, 10'd0}) begin
            errors++; $display("FAIL pulse_drop got ls=%b fs=%b h=%0d", ls_f, fs_f, h_f);
        end
    endtask

    task automatic test_line();
        obs_t ef, es;
        int   hs_low = 0;
        int   lines = 0;
        for (int i = 0; i < 800; i++) begin
            step(1'b1);
            ef = exp_f(); es = exp_s();
            checks += 2;
            if (obs_f !== ef) begin errors++; $display("FAIL line_full i=%0d got %h exp %h", i, obs_f, ef); end
            if (obs_s !== es) begin errors++; $display("FAIL line_small i=%0d got %h exp %h", i, obs_s, es); end
            if (!hs_f) hs_low++;
            if (ls_f) lines++;
            if (h_f == 10'd80) begin
                checks++;
                if (rgb_f !== (PATTERN ? 24'hFFFF00 : 24'h0)) begin errors++; $display("FAIL rgb_h80 got %h", rgb_f); end
            end
            if (h_f == 10'd639) begin
                checks++;
                if (rgb_f !== 24'h0) begin errors++; $display("FAIL rgb_h639 got %h", rgb_f); end
            end
            if (h_f == 10'd640) begin
                checks++;
                if (rgb_f !== 24'h0 || de_f !== 1'b0) begin errors++; $display("FAIL rgb_h640 got %h de=%b", rgb_f, de_f); end
            end
        end
        checks += 3;
        if (hs_low != 96) begin errors++; $display("FAIL hsync_width got %0d exp 96", hs_low); end
        if (lines != 1) begin errors++; $display("FAIL line_start_count got %0d exp 1", lines); end
        if (v_f !== 10'd1) begin errors++; $display("FAIL v_advance got %0d exp 1", v_f); end
    endtask

    task automatic test_frame();
        obs_t ef, es;
        int   frames = 0;
        int   vs_low = 0;
        int   de_hi = 0;
        for (int i = 0; i < 2 * 2480; i++) begin
            step(1'b1);
            ef = exp_f(); es = exp_s();
            checks += 2;
            if (obs_f !== ef) begin errors++; $display("FAIL frame_full i=%0d got %h exp %h", i, obs_f, ef); end
            if (obs_s !== es) begin errors++; $display("FAIL frame_small i=%0d got %h exp %h", i, obs_s, es); end
            if (fs_s) frames++;
            if (!vs_s) vs_low++;
            if (de_s) de_hi++;
        end
        checks += 3;
        if (frames != 2) begin errors++; $display("FAIL frame_count got %0d exp 2", frames); end
        if (vs_low != 320) begin errors++; $display("FAIL vsync_width got %0d exp 320", vs_low); end
        if (de_hi != 3072) begin errors++; $display("FAIL de_count got %0d exp 3072", de_hi); end
    endtask

    task automatic test_divider();
        obs_t ef, es;
        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < 500; i++) begin
                step(i == 0);
                ef = exp_f(); es = exp_s();
                checks += 2;
                if (obs_f !== ef) begin errors++; $display("FAIL div_full k=%0d i=%0d got %h exp %h", k, i, obs_f, ef); end
                if (obs_s !== es) begin errors++; $display("FAIL div_small k=%0d i=%0d got %h exp %h", k, i, obs_s, es); end
            end
        end
    endtask

    task automatic test_random();
        obs_t ef, es;
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)));
            ef = exp_f(); es = exp_s();
            checks += 2;
            if (obs_f !== ef) begin errors++; $display("FAIL rand_full i=%0d got %h exp %h", i, obs_f, ef); end
            if (obs_s !== es) begin errors++; $display("FAIL rand_small i=%0d got %h exp %h", i, obs_s, es); end
        end
    endtask

    task automatic test_mid_reset();
        obs_t   ef, es;
        longint cur, k;
        cur = (2479 + n) % 2480;
        k   = (990 - cur + 2480) % 2480;
        for (longint i = 0; i < k; i++) begin
            step(1'b1);
            es = exp_s();
            checks++;
            if (obs_s !== es) begin errors++; $display("FAIL pre_reset_small got %h exp %h", obs_s, es); end
        end
        checks++;
        if (h_s !== 10'd30 || v_s !== 10'd12) begin
            errors++; $display("FAIL pre_reset_pos got h=%0d v=%0d exp h=30 v=12", h_s, v_s);
        end
        pm = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        n = 0;
        pulsed = 1'b0;
        ef = exp_f(); es = exp_s();
        checks += 3;
        if (obs_f !== ef) begin errors++; $display("FAIL async_reset_full got %h exp %h", obs_f, ef); end
        if (obs_s !== es) begin errors++; $display("FAIL async_reset_small got %h exp %h", obs_s, es); end
        if ({h_s, v_s, ls_s, fs_s, de_s} !== {10'd79, 10'd30, 3'b000}) begin
            errors++; $display("FAIL async_reset_const got h=%0d v=%0d", h_s, v_s);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1);
        ef = exp_f(); es = exp_s();
        checks += 3;
        if (obs_f !== ef) begin errors++; $display("FAIL post_reset_full got %h exp %h", obs_f, ef); end
        if (obs_s !== es) begin errors++; $display("FAIL post_reset_small got %h exp %h", obs_s, es); end
        if ({h_s, v_s, fs_s, ls_s} !== {10'd0, 10'd0, 2'b11}) begin
            errors++; $display("FAIL post_reset_const got h=%0d v=%0d fs=%b", h_s, v_s, fs_s);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n = 0;
        pulsed = 1'b0;
        test_reset();
        test_first_pm();
        test_line();
        test_frame();
        test_divider();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch (pixels).
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width (pixels).
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch (pixels); H_TOTAL = sum = 800.
REQ-005 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (lines); V_TOTAL = 525.
REQ-006 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port pm  input  1  pixel-advance enable pulse from the upstream divider, sampled on clk.
REQ-009 SHALL have ports h_cnt  output  10 and v_cnt  output  10, the current pixel column and line.
REQ-010 SHALL have ports hsync, vsync  output  1 each, active-low sync.
REQ-011 SHALL have port de  output  1  high while (h_cnt, v_cnt) lies in the active area.
REQ-012 SHALL have ports line_start, frame_start  output  1 each, one-clk pulses.
REQ-013 SHALL have port rgb  output  24  pixel colour {R[7:0],G[7:0],B[7:0]}.

Function
REQ-014 SHALL change all state only on a clk edge where pm=1; pm=0 holds every output, and pulses drop to 0.
REQ-015 SHALL advance h_cnt by 1 per pm, wrapping from H_TOTAL-1 to 0.
REQ-016 SHALL advance v_cnt by 1 only on an h_cnt wrap, wrapping from V_TOTAL-1 to 0; otherwise hold v_cnt.
REQ-017 SHALL register hsync, vsync and de on the same edge as the counters, decoded from the new counter values, with zero latency relative to h_cnt/v_cnt.
REQ-018 SHALL drive hsync=0 for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751], else 1.
REQ-019 SHALL drive vsync=0 for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491], else 1.
REQ-020 SHALL drive de=1 when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-021 SHALL pulse line_start for one clk when the counters load h_cnt=0; it SHALL pulse frame_start when they load (0,0), together with line_start.
REQ-022 SHALL accept pm held high continuously, advancing one pixel per clk with no skipped or repeated position.
REQ-023 SHALL use 10-bit unsigned compares; parameter sums that exceed 1023 are illegal configurations.

Reset
REQ-024 SHALL on rst=1 asynchronously load h_cnt=H_TOTAL-1 (799) and v_cnt=V_TOTAL-1 (524), and set hsync=1, vsync=1, de=0, line_start=0, frame_start=0, rgb=0.
REQ-025 SHALL make the first pm after reset release move the counters to (0,0) with frame_start=1 and de=1.
REQ-026 SHALL abandon any partial frame on mid-frame reset, with no residual pulse.

Configuration
REQ-027 SHALL, with VGA_TEST_PATTERN_EN defined, drive rgb as 8 vertical colour bars of H_ACTIVE/8 = 80 pixels each: white, yellow, cyan, green, magenta, red, blue, black. Each channel is 8'hFF or 8'h00. rgb is registered with de and is 0 when de=0.
REQ-028 SHALL, without VGA_TEST_PATTERN_EN, keep the rgb port present and tie it to 24'h0.

Structure
REQ-029 SHALL place the default 640x480 timing constants and the colour-bar table in a shared package vga_pkg.
REQ-030 SHALL implement each axis with one sub-module vga_axis_cnt (enable, terminal count, wrap flag), instantiated for H and V.

Verification
REQ-031 Reset, then a single pm -> h_cnt=0, v_cnt=0, de=1, frame_start=1, line_start=1, hsync=1, vsync=1.
REQ-032 pm every clk for 800 clks -> hsync low exactly for h_cnt 656..751 (96 clks); line_start on h_cnt=0; v_cnt increments once.
REQ-033 pm every clk for 420000 clks -> exactly one frame_start per 420000 clks; vsync low for lines 490..491 (1600 clks); de high for 307200 clks.
REQ-034 pm once every 500 clks (divider rate) -> counters advance only on pm edges; outputs stable between pulses; pulses last one clk.
REQ-035 rst asserted at (h=300, v=200) -> outputs take reset values immediately without a clk edge; next pm gives (0,0) with frame_start=1.
REQ-036 With VGA_TEST_PATTERN_EN: rgb=24'hFFFFFF at h=0, 24'hFFFF00 at h=80, 24'h000000 at h=639, 0 at h=640. Without the macro: rgb=0 throughout.
